// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hard-wired ALU instruction sequencer:
// state encoding, opcode values, ALU function codes and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_OP_PASS = 4'd0;
  localparam logic [3:0] ALU_OP_ADD  = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_AND  = 4'd3;
  localparam logic [3:0] ALU_OP_OR   = 4'd4;
  localparam logic [3:0] ALU_OP_SHR  = 4'd5;
  localparam logic [3:0] ALU_OP_SHL  = 4'd6;
  localparam logic [3:0] ALU_OP_ROR  = 4'd7;
  localparam logic [3:0] ALU_OP_ROL  = 4'd8;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int REG_IDX_W = 4;

  // Maps an instruction opcode to the datapath ALU function; PASS for non-ALU opcodes.
  function automatic logic [3:0] alu_op_of(input logic [4:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_OP_ADD;
      OP_SUB:  return ALU_OP_SUB;
      OP_AND:  return ALU_OP_AND;
      OP_OR:   return ALU_OP_OR;
      OP_SHR:  return ALU_OP_SHR;
      OP_SHL:  return ALU_OP_SHL;
      OP_ROR:  return ALU_OP_ROR;
      OP_ROL:  return ALU_OP_ROL;
      default: return ALU_OP_PASS;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [4:0] opcode);
    return alu_op_of(opcode) != ALU_OP_PASS;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder with enable; indices at or above
// NUM_REGS decode to all zeros.
module reg_onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                i_en,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_en && (i_idx == IDX_W'(i))) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hard-wired T0-T5 control sequencer for register-register ALU instructions:
// fetch via PC/MAR/MDR with memory wait, decode IR, drive datapath strobes.
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ALU_OP_W = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Run,
  input  logic                Mem_ready,
  input  logic [DATA_W-1:0]   Ir_q,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic [NUM_REGS-1:0] R_out,
  output logic [NUM_REGS-1:0] R_in,
  output logic [ALU_OP_W-1:0] Alu_op,
  output logic                Halted,
  output logic                Illegal,
  output logic                Instr_done
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_first_t1;
  logic [4:0]             r_opcode;
  logic [REG_IDX_W-1:0]   r_ra;
  logic [REG_IDX_W-1:0]   r_rb;
  logic [REG_IDX_W-1:0]   r_rc;

  logic [4:0]             w_opcode;
  logic [REG_IDX_W-1:0]   w_ra;
  logic [REG_IDX_W-1:0]   w_rb;
  logic [REG_IDX_W-1:0]   w_rc;
  logic                   w_regs_ok;
  logic                   w_is_alu;
  logic                   w_is_nop;
  logic                   w_is_halt;
  logic                   w_rout_en;
  logic                   w_rin_en;
  logic [REG_IDX_W-1:0]   w_rout_idx;
  logic                   w_unused_ir_bits;

  assign w_unused_ir_bits = &{1'b0, Ir_q[RC_LSB-1:0]};

  // IR is written by the datapath on the T2 edge, so T3 decodes Ir_q directly
  // and the latched copy serves T4/T5.
  assign w_opcode = (r_state == ST_T3) ? Ir_q[OPC_MSB:OPC_LSB] : r_opcode;
  assign w_ra     = (r_state == ST_T3) ? Ir_q[RA_MSB:RA_LSB]   : r_ra;
  assign w_rb     = (r_state == ST_T3) ? Ir_q[RB_MSB:RB_LSB]   : r_rb;
  assign w_rc     = (r_state == ST_T3) ? Ir_q[RC_MSB:RC_LSB]   : r_rc;

  assign w_regs_ok = ({1'b0, w_ra} < 5'(NUM_REGS)) && ({1'b0, w_rb} < 5'(NUM_REGS)) &&
                     ({1'b0, w_rc} < 5'(NUM_REGS));
  assign w_is_alu  = is_alu_op(w_opcode) && w_regs_ok;
  assign w_is_nop  = (w_opcode == OP_NOP)  && w_regs_ok;
  assign w_is_halt = (w_opcode == OP_HALT) && w_regs_ok;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_first_t1 <= 1'b0;
      r_opcode   <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_next;
      r_first_t1 <= (r_state == ST_T0);
      if (r_state == ST_T3) begin
        r_opcode <= w_opcode;
        r_ra     <= w_ra;
        r_rb     <= w_rb;
        r_rc     <= w_rc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (Run) w_state_next = ST_T0;
      ST_T0:   w_state_next = ST_T1;
      ST_T1:   if (Mem_ready) w_state_next = ST_T2;
      ST_T2:   w_state_next = ST_T3;
      ST_T3: begin
        if (w_is_alu)       w_state_next = ST_T4;
        else if (w_is_halt) w_state_next = ST_HALT;
        else                w_state_next = Run ? ST_T0 : ST_IDLE;
      end
      ST_T4:   w_state_next = ST_T5;
      ST_T5:   w_state_next = Run ? ST_T0 : ST_IDLE;
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Alu_op     = '0;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    Instr_done = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = w_rb;
    w_rin_en   = 1'b0;
    case (r_state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = r_first_t1;
        Zlowout = r_first_t1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (w_is_alu) begin
          w_rout_en = 1'b1;
          Yin       = 1'b1;
        end else if (w_is_nop || w_is_halt) begin
          Instr_done = 1'b1;
        end else begin
          Illegal = 1'b1;
        end
      end
      ST_T4: begin
        w_rout_en  = 1'b1;
        w_rout_idx = w_rc;
        Zin        = 1'b1;
        Alu_op     = ALU_OP_W'(alu_op_of(w_opcode));
      end
      ST_T5: begin
        Zlowout    = 1'b1;
        w_rin_en   = 1'b1;
        Instr_done = 1'b1;
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rout_dec (
    .i_en     (w_rout_en),
    .i_idx    (w_rout_idx),
    .o_onehot (R_out)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rin_dec (
    .i_en     (w_rin_en),
    .i_idx    (w_ra),
    .o_onehot (R_in)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: fetch/decode/execute sequences,
// memory wait, illegal decode (16 and 8 registers), halt and async reset.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Run;
  logic        Mem_ready;
  logic [31:0] Ir_q;

  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic [15:0] R_out, R_in;
  logic [3:0]  Alu_op;
  logic        Halted, Illegal, Instr_done;

  logic PCout8, MARin8, IncPC8, PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8, Zin8, Zlowout8;
  logic [7:0]  R_out8, R_in8;
  logic [3:0]  Alu_op8;
  logic        Halted8, Illegal8, Instr_done8;

  int tests = 0;
  int fails = 0;
  logic inv_on = 1'b0;

  localparam logic [10:0] S_NONE = 11'b00000000000;
  localparam logic [10:0] S_T0   = 11'b11100000010;
  localparam logic [10:0] S_T1F  = 11'b00011100001;
  localparam logic [10:0] S_T1W  = 11'b00001100000;
  localparam logic [10:0] S_T2   = 11'b00000011000;
  localparam logic [10:0] S_YIN  = 11'b00000000100;
  localparam logic [10:0] S_ZIN  = 11'b00000000010;
  localparam logic [10:0] S_ZLO  = 11'b00000000001;

  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(16), .ALU_OP_W(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .Ir_q(Ir_q),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .R_out(R_out), .R_in(R_in), .Alu_op(Alu_op), .Halted(Halted), .Illegal(Illegal),
    .Instr_done(Instr_done)
  );

  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(8), .ALU_OP_W(4)) dut8 (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .Ir_q(Ir_q),
    .PCout(PCout8), .MARin(MARin8), .IncPC(IncPC8), .PCin(PCin8), .Read(Read8), .MDRin(MDRin8),
    .MDRout(MDRout8), .IRin(IRin8), .Yin(Yin8), .Zin(Zin8), .Zlowout(Zlowout8),
    .R_out(R_out8), .R_in(R_in8), .Alu_op(Alu_op8), .Halted(Halted8), .Illegal(Illegal8),
    .Instr_done(Instr_done8)
  );

  always #5 Clock = ~Clock;

  logic [49:0] all16, all8;
  assign all16 = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                  R_out, R_in, Alu_op, Halted, Illegal, Instr_done};
  assign all8  = {PCout8, MARin8, IncPC8, PCin8, Read8, MDRin8, MDRout8, IRin8, Yin8, Zin8,
                  Zlowout8, 8'h00, R_out8, 8'h00, R_in8, Alu_op8, Halted8, Illegal8, Instr_done8};

  function automatic logic [49:0] ev(input logic [10:0] s, input logic [15:0] ro,
                                     input logic [15:0] ri, input logic [3:0] op,
                                     input logic h, input logic il, input logic d);
    return {s, ro, ri, op, h, il, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Structural rules: one-hot0 selects and a single bus driver, on both instances.
  always @(negedge Clock) begin
    if (inv_on && Reset_n) begin
      check("bus_rules16", {61'd0, $onehot0(R_out), $onehot0(R_in),
            ($countones({PCout, MDRout, Zlowout, |R_out}) <= 1)}, 64'd7);
      check("bus_rules8", {61'd0, $onehot0(R_out8), $onehot0(R_in8),
            ($countones({PCout8, MDRout8, Zlowout8, |R_out8}) <= 1)}, 64'd7);
    end
  end

  // Holds reset two cycles, releases it; returns at the negedge after the first edge.
  task automatic reset_dut(input logic run_lvl);
    Reset_n   = 1'b0;
    Run       = run_lvl;
    Mem_ready = 1'b1;
    repeat (2) tick();
    check("reset_outputs", 64'(all16), 64'd0);
    Reset_n = 1'b1;
    tick();
  endtask

  // Starts at a negedge in T0 and returns at the negedge of the following T0.
  task automatic run_alu(input string tag, input logic [31:0] ir, input int wait_cyc,
                         input logic [15:0] rb1h, input logic [15:0] rc1h,
                         input logic [3:0] op, input logic [15:0] ra1h);
    Ir_q = ir;
    check({tag, "_t0"}, 64'(all16), 64'(ev(S_T0, 0, 0, 0, 0, 0, 0)));
    Mem_ready = (wait_cyc == 0);
    tick();
    check({tag, "_t1_first"}, 64'(all16), 64'(ev(S_T1F, 0, 0, 0, 0, 0, 0)));
    for (int k = 1; k <= wait_cyc; k++) begin
      tick();
      check({tag, "_t1_wait"}, 64'(all16), 64'(ev(S_T1W, 0, 0, 0, 0, 0, 0)));
      if (k == wait_cyc) Mem_ready = 1'b1;
    end
    tick();
    check({tag, "_t2"}, 64'(all16), 64'(ev(S_T2, 0, 0, 0, 0, 0, 0)));
    tick();
    check({tag, "_t3"}, 64'(all16), 64'(ev(S_YIN, rb1h, 0, 0, 0, 0, 0)));
    tick();
    check({tag, "_t4"}, 64'(all16), 64'(ev(S_ZIN, rc1h, 0, op, 0, 0, 0)));
    tick();
    check({tag, "_t5"}, 64'(all16), 64'(ev(S_ZLO, 0, ra1h, 0, 0, 0, 1)));
    tick();
  endtask

  initial begin
    int bad;
    Reset_n   = 1'b0;
    Run       = 1'b0;
    Mem_ready = 1'b1;
    Ir_q      = 32'h28918000;
    inv_on    = 1'b1;

    // and r1,r2,r3 with no memory wait, then with three wait cycles
    reset_dut(1'b1);
    run_alu("and", 32'h28918000, 0, 16'h0004, 16'h0008, 4'd3, 16'h0002);
    run_alu("and_wait", 32'h28918000, 3, 16'h0004, 16'h0008, 4'd3, 16'h0002);
    run_alu("add", 32'h18918000, 0, 16'h0004, 16'h0008, 4'd1, 16'h0002);
    run_alu("shl", 32'h41118000, 0, 16'h0004, 16'h0008, 4'd6, 16'h0004);

    // undefined opcode 11111
    Ir_q = 32'hF8000000;
    check("ill_t0", 64'(all16), 64'(ev(S_T0, 0, 0, 0, 0, 0, 0)));
    repeat (3) tick();
    check("ill_t3", 64'(all16), 64'(ev(S_NONE, 0, 0, 0, 0, 1, 0)));
    tick();
    check("ill_next_t0", 64'(all16), 64'(ev(S_T0, 0, 0, 0, 0, 0, 0)));

    // ra=9 on the 8-register instance
    Ir_q = 32'h2C800000;
    reset_dut(1'b1);
    check("ill8_t0", 64'(all8), 64'(ev(S_T0, 0, 0, 0, 0, 0, 0)));
    repeat (3) tick();
    check("ill8_t3", 64'(all8), 64'(ev(S_NONE, 0, 0, 0, 0, 1, 0)));
    tick();
    check("ill8_next_t0", 64'(all8), 64'(ev(S_T0, 0, 0, 0, 0, 0, 0)));

    // halt
    Ir_q = 32'hD8000000;
    reset_dut(1'b1);
    repeat (3) tick();
    check("halt_t3", 64'(all16), 64'(ev(S_NONE, 0, 0, 0, 0, 0, 1)));
    tick();
    check("halt_enter", 64'(all16), 64'(ev(S_NONE, 0, 0, 0, 1, 0, 0)));
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (all16 !== ev(S_NONE, 0, 0, 0, 1, 0, 0)) bad++;
    end
    check("halt_hold_bad_cycles", 64'(bad), 64'd0);

    // async reset mid-T4, then release with Run=0
    Ir_q = 32'h28918000;
    reset_dut(1'b1);
    repeat (4) tick();
    check("rst_pre_t4", 64'(all16), 64'(ev(S_ZIN, 16'h0008, 0, 4'd3, 0, 0, 0)));
    #2 Reset_n = 1'b0;
    #1 check("rst_async_zero", 64'(all16), 64'd0);
    tick();
    Run     = 1'b0;
    Reset_n = 1'b1;
    repeat (3) tick();
    check("rst_idle_run0", 64'(all16), 64'd0);

    inv_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
